// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes and datapath select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from ALUOp and instruction function fields.
// The unsupported flag depends only on funct3 so DECODE can flag shifts before execute.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] ALUControl,
    output logic       unsupported
);

    always_comb begin
        ALUControl  = ALU_ADD;
        unsupported = (funct3 == 3'b001) || (funct3 == 3'b101);
        case (ALUOp)
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  ALUControl = ALU_AND;
                    3'b110:  ALUControl = ALU_OR;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default:     ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core.
// Optional MEM_HANDSHAKE_EN: FETCH/MEMREAD/MEMWRITE wait for mem_ready.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       LessThan,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       funct_unsup;
    logic       rdy;
    logic       pcw, irw, mw, rw, done, ill;
    logic       op_known, op_alu;

`ifdef MEM_HANDSHAKE_EN
    assign rdy = mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign rdy = 1'b1;
`endif

    alu_decoder u_alu_dec (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl),
        .unsupported(funct_unsup)
    );

    assign op_alu   = (op == OP_RTYPE) || (op == OP_ITYPE);
    assign op_known = op_alu || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH) ||
                      (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (rdy) state_d = S_MEMWB;
            S_MEMWRITE: if (rdy) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_JALR2:    state_d = S_ALUWB;
            S_JALR1:    state_d = S_JALR2;
            default:    state_d = S_FETCH;
        endcase
    end

    // Enables are built ungated here and forced low under reset below.
    always_comb begin
        pcw       = 1'b0;
        irw       = 1'b0;
        mw        = 1'b0;
        rw        = 1'b0;
        done      = 1'b0;
        ill       = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_WD;
        ImmSrc    = IMM_I;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                irw       = rdy;
                pcw       = rdy;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                ill     = !op_known || (op_alu && funct_unsup);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw        = 1'b1;
                done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mw     = 1'b1;
                done   = rdy;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                rw   = 1'b1;
                done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_SUB;
                done    = 1'b1;
                case (funct3)
                    3'b000:  pcw = Zero;
                    3'b001:  pcw = !Zero;
                    3'b100:  pcw = LessThan;
                    3'b101:  pcw = !LessThan;
                    default: pcw = 1'b0;
                endcase
            end
            S_JAL, S_JALR2: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pcw     = 1'b1;
            end
            S_JALR1: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMM;
                rw        = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite    = pcw  && !rst;
    assign IRWrite    = irw  && !rst;
    assign MemWrite   = mw   && !rst;
    assign RegWrite   = rw   && !rst;
    assign instr_done = done && !rst;
    assign illegal    = ill  && !rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle bench for multicycle_controller; define MEM_HANDSHAKE_EN for the handshake sequence.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0, Zero = 1'b0, LessThan = 1'b0, mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .LessThan(LessThan), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done), .illegal(illegal)
    );

    // {pcw, adr, irw, mw, rw, res, srca, srcb, alu, imm, done, ill}
    typedef logic [20:0] ctl_t;
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, lt, rdy;
        ctl_t       exp;
        string      name;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic ctl_t mk(input logic pcw, adr, irw, mw, rw, input logic [1:0] res, sa, sb,
                                input logic [2:0] alu, imm, input logic done, ill);
        return {pcw, adr, irw, mw, rw, res, sa, sb, alu, imm, done, ill};
    endfunction

    function automatic ctl_t c_fetch();  return mk(1,0,1,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0); endfunction
    function automatic ctl_t c_decode(); return mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,0,0); endfunction
    function automatic ctl_t c_aluwb();  return mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,1,0); endfunction
    function automatic ctl_t c_jal();    return mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000,0,0); endfunction
    function automatic ctl_t c_execr(input logic [2:0] a); return mk(0,0,0,0,0,2'b00,2'b10,2'b00,a,3'b000,0,0); endfunction
    function automatic ctl_t c_execi(input logic [2:0] a); return mk(0,0,0,0,0,2'b00,2'b10,2'b01,a,3'b000,0,0); endfunction
    function automatic ctl_t c_branch(input logic t);      return mk(t,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,1,0); endfunction

    task automatic add(input string n, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, z, lt, input ctl_t e);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.rdy = 1'b1; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic instr_rtype(input string n, input logic [2:0] f3, input logic f7, input logic [2:0] a);
        add({n,".fetch"}, 7'b0110011, f3, f7, 0, 0, c_fetch());
        add({n,".decode"}, 7'b0110011, f3, f7, 0, 0, c_decode());
        add({n,".execr"}, 7'b0110011, f3, f7, 0, 0, c_execr(a));
        add({n,".aluwb"}, 7'b0110011, f3, f7, 0, 0, c_aluwb());
    endtask

    task automatic instr_branch(input string n, input logic [2:0] f3, input logic z, lt, input logic t);
        add({n,".fetch"}, 7'b1100011, f3, 0, z, lt, c_fetch());
        add({n,".decode"}, 7'b1100011, f3, 0, z, lt, c_decode());
        add({n,".branch"}, 7'b1100011, f3, 0, z, lt, c_branch(t));
    endtask

    task automatic cyc(input string n, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, z, lt, rdy, input ctl_t e);
        ctl_t got;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; LessThan = lt; mem_ready = rdy;
        @(negedge clk);
        got = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, instr_done, illegal};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_cycle(input string n);
        @(negedge clk);
        checks++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal} !== 6'b0) begin
            errors++;
            $display("FAIL %s: enables got %b expected 000000", n,
                     {PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        instr_rtype("add", 3'b000, 1'b0, 3'b000);
        instr_rtype("sub", 3'b000, 1'b1, 3'b001);
        instr_rtype("slt", 3'b010, 1'b0, 3'b101);
        instr_rtype("sltu", 3'b011, 1'b0, 3'b110);
        instr_rtype("or", 3'b110, 1'b0, 3'b011);
        instr_rtype("xor", 3'b100, 1'b0, 3'b100);
        instr_branch("beq_z1", 3'b000, 1, 0, 1);
        instr_branch("bne_z1", 3'b001, 1, 0, 0);
        instr_branch("blt_lt1", 3'b100, 0, 1, 1);
        instr_branch("bge_lt1", 3'b101, 0, 1, 0);
        instr_branch("bne_z0", 3'b001, 0, 0, 1);
        instr_branch("bf3_010", 3'b010, 1, 1, 0);
        // lw
        add("lw.fetch",  7'b0000011, 3'b010, 0, 0, 0, c_fetch());
        add("lw.decode", 7'b0000011, 3'b010, 0, 0, 0, c_decode());
        add("lw.memadr", 7'b0000011, 3'b010, 0, 0, 0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0));
        add("lw.memread",7'b0000011, 3'b010, 0, 0, 0, mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
        add("lw.memwb",  7'b0000011, 3'b010, 0, 0, 0, mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,1,0));
        // sw
        add("sw.fetch",  7'b0100011, 3'b010, 0, 0, 0, c_fetch());
        add("sw.decode", 7'b0100011, 3'b010, 0, 0, 0, c_decode());
        add("sw.memadr", 7'b0100011, 3'b010, 0, 0, 0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0,0));
        add("sw.memwr",  7'b0100011, 3'b010, 0, 0, 0, mk(0,1,0,1,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,0));
        // andi, then slli (flagged illegal in DECODE but still executes as ADD)
        add("andi.fetch",  7'b0010011, 3'b111, 0, 0, 0, c_fetch());
        add("andi.decode", 7'b0010011, 3'b111, 0, 0, 0, c_decode());
        add("andi.execi",  7'b0010011, 3'b111, 0, 0, 0, c_execi(3'b010));
        add("andi.aluwb",  7'b0010011, 3'b111, 0, 0, 0, c_aluwb());
        add("slli.fetch",  7'b0010011, 3'b001, 0, 0, 0, c_fetch());
        add("slli.decode", 7'b0010011, 3'b001, 0, 0, 0, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,0,1));
        add("slli.execi",  7'b0010011, 3'b001, 0, 0, 0, c_execi(3'b000));
        add("slli.aluwb",  7'b0010011, 3'b001, 0, 0, 0, c_aluwb());
        add("addi_f7.execi_chk_fetch", 7'b0010011, 3'b000, 1, 0, 0, c_fetch());
        add("addi_f7.decode", 7'b0010011, 3'b000, 1, 0, 0, c_decode());
        add("addi_f7.execi",  7'b0010011, 3'b000, 1, 0, 0, c_execi(3'b000));
        add("addi_f7.aluwb",  7'b0010011, 3'b000, 1, 0, 0, c_aluwb());
        // jal
        add("jal.fetch",  7'b1101111, 3'b000, 0, 0, 0, c_fetch());
        add("jal.decode", 7'b1101111, 3'b000, 0, 0, 0, c_decode());
        add("jal.jal",    7'b1101111, 3'b000, 0, 0, 0, c_jal());
        add("jal.aluwb",  7'b1101111, 3'b000, 0, 0, 0, c_aluwb());
        // jalr
        add("jalr.fetch",  7'b1100111, 3'b000, 0, 0, 0, c_fetch());
        add("jalr.decode", 7'b1100111, 3'b000, 0, 0, 0, c_decode());
        add("jalr.jalr1",  7'b1100111, 3'b000, 0, 0, 0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0));
        add("jalr.jalr2",  7'b1100111, 3'b000, 0, 0, 0, c_jal());
        add("jalr.aluwb",  7'b1100111, 3'b000, 0, 0, 0, c_aluwb());
        // lui
        add("lui.fetch",  7'b0110111, 3'b000, 0, 0, 0, c_fetch());
        add("lui.decode", 7'b0110111, 3'b000, 0, 0, 0, c_decode());
        add("lui.lui",    7'b0110111, 3'b000, 0, 0, 0, mk(0,0,0,0,1,2'b11,2'b00,2'b00,3'b000,3'b100,1,0));
        // unsupported opcode
        add("ill.fetch",  7'h7F, 3'b000, 0, 0, 0, c_fetch());
        add("ill.decode", 7'h7F, 3'b000, 0, 0, 0, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,0,1));
        add("ill.refetch",7'b0110011, 3'b000, 0, 0, 0, c_fetch());
        add("ill.next_decode", 7'b0110011, 3'b000, 0, 0, 0, c_decode());
        add("ill.next_execr",  7'b0110011, 3'b000, 0, 0, 0, c_execr(3'b000));
        add("ill.next_aluwb",  7'b0110011, 3'b000, 0, 0, 0, c_aluwb());

        // reset held for 3 cycles
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check_reset_cycle($sformatf("reset%0d", i));
        rst = 1'b0;

        foreach (vecs[i])
            cyc(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].lt, 1'b1, vecs[i].exp);

        // reset mid-lw aborts the instruction; first cycle after release is FETCH
        cyc("abort.fetch",  7'b0000011, 3'b010, 0, 0, 0, 1, c_fetch());
        cyc("abort.decode", 7'b0000011, 3'b010, 0, 0, 0, 1, c_decode());
        rst = 1'b1;
        check_reset_cycle("abort.rst");
        rst = 1'b0;
        cyc("abort.refetch", 7'b0000011, 3'b010, 0, 0, 0, 1, c_fetch());
        cyc("abort.redecode",7'b0000011, 3'b010, 0, 0, 0, 1, c_decode());
        cyc("abort.memadr",  7'b0000011, 3'b010, 0, 0, 0, 1,
            mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0));
        cyc("abort.memread", 7'b0000011, 3'b010, 0, 0, 0, 1,
            mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
        cyc("abort.memwb",   7'b0000011, 3'b010, 0, 0, 0, 1,
            mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,1,0));

`ifdef MEM_HANDSHAKE_EN
        // sw with FETCH stalled once, then MEMWRITE stalled 3 cycles
        cyc("hs.fetch_wait", 7'b0100011, 3'b010, 0, 0, 0, 0,
            mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));
        cyc("hs.fetch", 7'b0100011, 3'b010, 0, 0, 0, 1, c_fetch());
        cyc("hs.decode", 7'b0100011, 3'b010, 0, 0, 0, 0, c_decode());
        cyc("hs.memadr", 7'b0100011, 3'b010, 0, 0, 0, 0,
            mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0,0));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("hs.memwr_wait%0d", i), 7'b0100011, 3'b010, 0, 0, 0, 0,
                mk(0,1,0,1,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
        cyc("hs.memwr_done", 7'b0100011, 3'b010, 0, 0, 0, 1,
            mk(0,1,0,1,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,0));
        cyc("hs.next_fetch", 7'b0100011, 3'b010, 0, 0, 0, 1, c_fetch());
`else
        // without the handshake mem_ready is ignored
        cyc("nohs.fetch", 7'b0100011, 3'b010, 0, 0, 0, 0, c_fetch());
        cyc("nohs.decode", 7'b0100011, 3'b010, 0, 0, 0, 0, c_decode());
        cyc("nohs.memadr", 7'b0100011, 3'b010, 0, 0, 0, 0,
            mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0,0));
        cyc("nohs.memwr", 7'b0100011, 3'b010, 0, 0, 0, 0,
            mk(0,1,0,1,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,0));
        cyc("nohs.next_fetch", 7'b0100011, 3'b010, 0, 0, 0, 0, c_fetch());
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
